eth_mdio_master: RTL and testbench

ETH_MDIO_MASTER -- requirements
Module: eth_mdio_master

---
 rtl/eth_pkg.sv | 46 ++++
 rtl/eth_mdc_gen.sv | 40 ++++
 rtl/eth_mdio_master.sv | 186 ++++++++++++++++++
 tb/tb_eth_mdio_master.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the MDIO master: FSM encoding, frame field constants
// and the bit layout of the status word.
package eth_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_CMD,
    S_TA,
    S_DATA,
    S_DONE
  } mdio_state_e;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  // Bit counter values at which each frame section ends.
  localparam logic [5:0] PRE_LAST   = 6'd31;
  localparam logic [5:0] CMD_LAST   = 6'd45;
  localparam logic [5:0] TA_LAST    = 6'd47;
  localparam logic [5:0] FRAME_LAST = 6'd63;

  localparam int STAT_READY    = 7;
  localparam int STAT_SPEED_HI = 6;
  localparam int STAT_SPEED_LO = 5;
  localparam int STAT_DUPLEX   = 4;
  localparam int STAT_MDIX     = 2;
  localparam int STAT_RXOK     = 1;
  localparam int STAT_LINK     = 0;

  // Map the polled PHY register onto the low seven status bits.
  function automatic logic [6:0] poll_status(input logic [15:0] r);
    logic [6:0] s;
    s                = '0;
    s[STAT_SPEED_HI] = r[15];
    s[STAT_SPEED_LO] = r[14];
    s[STAT_DUPLEX]   = r[13];
    s[STAT_MDIX]     = r[6];
    s[STAT_RXOK]     = r[11];
    s[STAT_LINK]     = r[10];
    return s;
  endfunction

endpackage

// File: rtl/eth_mdc_gen.sv
// MDC divider: toggles mdc every CLKDIV clocks while enabled and flags the
// cycle before each rising/falling transition.
module eth_mdc_gen #(
  parameter int CLKDIV = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic mdc_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int DW = (CLKDIV < 2) ? 1 : $clog2(CLKDIV);

  logic [DW-1:0] div_q;
  logic          mdc_q;
  logic          tick;

  assign tick   = en_i && (div_q == DW'(CLKDIV - 1));
  assign rise_o = tick && !mdc_q;
  assign fall_o = tick && mdc_q;
  assign mdc_o  = mdc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
      mdc_q <= 1'b0;
    end else if (!en_i) begin
      div_q <= '0;
      mdc_q <= 1'b0;
    end else if (tick) begin
      div_q <= '0;
      mdc_q <= ~mdc_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

endmodule

// File: rtl/eth_mdio_master.sv
// Clause-22 MDIO master with one user read/write channel and a background
// link-status poller that shares the same frame engine.
module eth_mdio_master
  import eth_pkg::*;
#(
  parameter int          CLKDIV  = 20,
  parameter logic [4:0]  PHYADR  = 5'h00,
  parameter logic [4:0]  POLLREG = 5'd17,
  parameter logic [23:0] POLLGAP = 24'd1000000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [6:0]  md_ctrl_i,
  input  logic [15:0] md_wdat_i,
  output logic [15:0] md_rdat_o,
  output logic [7:0]  md_status_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i
);

  mdio_state_e state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic        mdio_q, mdio_d;
  logic        oe_q, oe_d;
  logic        user_q, user_d;
  logic        frame_wr_q, frame_wr_d;
  logic        pend_q, pend_d;
  logic        req_wr_q, req_wr_d;
  logic [4:0]  req_reg_q, req_reg_d;
  logic [15:0] req_wdat_q, req_wdat_d;
  logic        start_q, start_d;
  logic        ready_q, ready_d;
  logic [6:0]  stat_q, stat_d;
  logic [15:0] rdat_q, rdat_d;
  logic [23:0] gap_q, gap_d;

  logic mdc_en, mdc_rise, mdc_fall;
  logic start_edge, user_busy, poll_due, launch_wr;
  logic [4:0] launch_reg;

  assign mdc_en = (state_q == S_PRE) || (state_q == S_CMD) ||
                  (state_q == S_TA)  || (state_q == S_DATA);

  eth_mdc_gen #(.CLKDIV(CLKDIV)) u_mdc (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .en_i   (mdc_en),
    .mdc_o  (mdc_o),
    .rise_o (mdc_rise),
    .fall_o (mdc_fall)
  );

  assign start_edge = md_ctrl_i[5] && !start_q;
  assign user_busy  = pend_q || (user_q && (state_q != S_IDLE));
  assign poll_due   = (POLLGAP != 24'd0) && (gap_q == POLLGAP - 24'd1);
  assign launch_wr  = pend_q ? req_wr_q : 1'b0;
  assign launch_reg = pend_q ? req_reg_q : POLLREG;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    mdio_d     = mdio_q;
    oe_d       = oe_q;
    user_d     = user_q;
    frame_wr_d = frame_wr_q;
    pend_d     = pend_q;
    req_wr_d   = req_wr_q;
    req_reg_d  = req_reg_q;
    req_wdat_d = req_wdat_q;
    start_d    = md_ctrl_i[5];
    ready_d    = ready_q;
    stat_d     = stat_q;
    rdat_d     = rdat_q;
    gap_d      = '0;

    if (start_edge && !user_busy) begin
      pend_d     = 1'b1;
      ready_d    = 1'b0;
      req_wr_d   = md_ctrl_i[6];
      req_reg_d  = md_ctrl_i[4:0];
      req_wdat_d = md_wdat_i;
    end

    unique case (state_q)
      S_IDLE: begin
        // A request already pending wins over an expiring poll timer.
        if (pend_q || poll_due) begin
          state_d    = S_PRE;
          cnt_d      = '0;
          mdio_d     = 1'b1;
          oe_d       = 1'b1;
          user_d     = pend_q;
          frame_wr_d = launch_wr;
          if (pend_q) pend_d = 1'b0;
          tx_d = {MDIO_ST, (launch_wr ? MDIO_OP_WR : MDIO_OP_RD), PHYADR,
                  launch_reg, MDIO_TA_WR, (pend_q ? req_wdat_q : 16'h0000)};
        end else if (POLLGAP != 24'd0) begin
          gap_d = gap_q + 24'd1;
        end
      end
      S_PRE, S_CMD, S_TA, S_DATA: begin
        if (mdc_rise) begin
          if (state_q == S_DATA) rx_d = {rx_q[14:0], mdio_i};
          if (cnt_q == FRAME_LAST) state_d = S_DONE;
        end
        if (mdc_fall) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q >= PRE_LAST) begin
            mdio_d = tx_q[31];
            tx_d   = {tx_q[30:0], 1'b0};
          end
          if (cnt_q == PRE_LAST) state_d = S_CMD;
          if (cnt_q == CMD_LAST) begin
            state_d = S_TA;
            if (!frame_wr_q) oe_d = 1'b0;
          end
          if (cnt_q == TA_LAST) state_d = S_DATA;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        oe_d    = 1'b0;
        mdio_d  = 1'b1;
        if (user_q) begin
          ready_d = 1'b1;
          if (!frame_wr_q) rdat_d = rx_q;
        end else begin
          stat_d = poll_status(rx_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      mdio_q     <= 1'b1;
      oe_q       <= 1'b0;
      user_q     <= 1'b0;
      frame_wr_q <= 1'b0;
      pend_q     <= 1'b0;
      req_wr_q   <= 1'b0;
      req_reg_q  <= '0;
      req_wdat_q <= '0;
      start_q    <= 1'b0;
      ready_q    <= 1'b1;
      stat_q     <= '0;
      rdat_q     <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      mdio_q     <= mdio_d;
      oe_q       <= oe_d;
      user_q     <= user_d;
      frame_wr_q <= frame_wr_d;
      pend_q     <= pend_d;
      req_wr_q   <= req_wr_d;
      req_reg_q  <= req_reg_d;
      req_wdat_q <= req_wdat_d;
      start_q    <= start_d;
      ready_q    <= ready_d;
      stat_q     <= stat_d;
      rdat_q     <= rdat_d;
      gap_q      <= gap_d;
    end
  end

  assign md_status_o = {ready_q, stat_q};
  assign md_rdat_o   = rdat_q;
  assign mdio_o      = mdio_q;
  assign mdio_oe_o   = oe_q;

endmodule

// File: tb/tb_eth_mdio_master.sv
// Directed bench: instance 0 has polling off, instance 1 polls every 100 idle
// cycles; each has a small PHY model that records the frame and answers reads.
module tb_eth_mdio_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  ctrl [2];
  logic [15:0] wdat [2];

  logic [7:0]  st_m    [2];
  logic [15:0] rd_m    [2];
  logic        mdc_m   [2];
  logic        mdo_m   [2];
  logic        oe_m    [2];
  int          rises_m [2];
  int          total_m [2];
  int          oel_m   [2];
  logic [63:0] cap_m   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] phy_reg(input logic [4:0] a);
    case (a)
      5'd17:   return 16'hAC00;
      5'd2:    return 16'h0141;
      default: return 16'hDEAD;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      logic [15:0] rdat;
      logic [7:0]  status;
      logic        mdc, mdo, oe;
      logic        mdi      = 1'b1;
      logic        mdc_prev = 1'b0;
      logic        oe_prev  = 1'b0;
      int          rises    = 0;
      int          total    = 0;
      int          oe_low   = 0;
      logic [63:0] cap      = '0;
      logic [4:0]  radr     = '0;
      logic [15:0] rword;
      logic        line;

      assign rword = phy_reg(radr);
      assign line  = oe ? mdo : mdi;

      eth_mdio_master #(
        .CLKDIV  (2),
        .PHYADR  (5'h01),
        .POLLREG (5'd17),
        .POLLGAP ((gi == 0) ? 24'd0 : 24'd100)
      ) u_dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .md_ctrl_i   (ctrl[gi]),
        .md_wdat_i   (wdat[gi]),
        .md_rdat_o   (rdat),
        .md_status_o (status),
        .mdc_o       (mdc),
        .mdio_o      (mdo),
        .mdio_oe_o   (oe),
        .mdio_i      (mdi)
      );

      // PHY model: frame starts when the master enables its driver.
      always @(negedge clk) begin
        mdc_prev <= mdc;
        oe_prev  <= oe;
        if (oe && !oe_prev) begin
          rises  <= 0;
          oe_low <= 0;
          mdi    <= 1'b1;
        end else if (mdc && !mdc_prev) begin
          cap   <= {cap[62:0], line};
          rises <= rises + 1;
          total <= total + 1;
          if (!oe) oe_low <= oe_low + 1;
          if (rises == 45) radr <= {cap[3:0], line};
        end else if (!mdc && mdc_prev) begin
          if (rises == 47) mdi <= 1'b0;
          else if (rises >= 48 && rises <= 63) mdi <= rword[4'(63 - rises)];
          else mdi <= 1'b1;
        end
      end

      assign st_m[gi]    = status;
      assign rd_m[gi]    = rdat;
      assign mdc_m[gi]   = mdc;
      assign mdo_m[gi]   = mdo;
      assign oe_m[gi]    = oe;
      assign rises_m[gi] = rises;
      assign total_m[gi] = total;
      assign oel_m[gi]   = oe_low;
      assign cap_m[gi]   = cap;
    end
  endgenerate

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_status(input int idx, input logic [7:0] mask, input logic [7:0] val,
                             input int budget, output bit ok, output bit dropped);
    ok = 1'b0;
    dropped = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (st_m[idx][7] !== 1'b1) dropped = 1'b1;
      if ((st_m[idx] & mask) === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rises(input int idx, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rises_m[idx] == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_oe_rise(input int idx, input int budget, output bit ok);
    logic prev;
    ok = 1'b0;
    prev = oe_m[idx];
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (oe_m[idx] === 1'b1 && prev === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prev = oe_m[idx];
    end
  endtask

  initial begin
    bit ok, dropped;
    int t0;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ctrl[i] = '0;
      wdat[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_status", 64'(st_m[0]), 64'h80);
    check("rst_rdat",   64'(rd_m[0]), 64'h0);
    check("rst_mdc",    64'(mdc_m[0]), 64'h0);
    check("rst_mdio",   64'(mdo_m[0]), 64'h1);
    check("rst_oe",     64'(oe_m[0]), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Read of reg 17 cut short by reset at data bit 5.
    ctrl[0] = 7'b0110001;
    wait_rises(0, 53, 600, ok);
    check("abort_reach_bit", 64'(ok), 64'h1);
    rst = 1'b1;
    ctrl[0] = '0;
    #1;
    check("abort_mdc",    64'(mdc_m[0]), 64'h0);
    check("abort_oe",     64'(oe_m[0]), 64'h0);
    check("abort_status", 64'(st_m[0]), 64'h80);
    check("abort_rdat",   64'(rd_m[0]), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    $display("reset during read: mdc=%b oe=%b status=%h rdat=%h", mdc_m[0], oe_m[0], st_m[0], rd_m[0]);

    // Background poll of reg 17 on instance 1.
    wait_status(1, 8'hFF, 8'hD3, 1000, ok, dropped);
    check("poll_done",    64'(ok), 64'h1);
    check("poll_ready",   64'(dropped), 64'h0);
    check("poll_rdat",    64'(rd_m[1]), 64'h0);
    check("poll_frame",   cap_m[1], 64'hFFFFFFFF_60C6AC00);
    check("poll_oe_low",  64'(oel_m[1]), 64'd18);
    $display("poll: status=%h frame=%h", st_m[1], cap_m[1]);

    // User write.
    wdat[0] = 16'hA5C3;
    ctrl[0] = 7'b1100100;
    @(negedge clk);
    check("wr_ready_low", 64'(st_m[0][7]), 64'h0);
    wait_status(0, 8'h80, 8'h80, 600, ok, dropped);
    check("wr_done",      64'(ok), 64'h1);
    check("wr_ready_at",  64'(rises_m[0]), 64'd64);
    check("wr_frame",     cap_m[0], 64'hFFFFFFFF_5092A5C3);
    check("wr_oe_low",    64'(oel_m[0]), 64'd0);
    check("wr_rdat",      64'(rd_m[0]), 64'h0);
    $display("write: frame=%h", cap_m[0]);
    ctrl[0] = '0;
    @(negedge clk);

    // User read.
    ctrl[0] = 7'b0100010;
    @(negedge clk);
    wait_status(0, 8'h80, 8'h80, 600, ok, dropped);
    check("rd_done",   64'(ok), 64'h1);
    check("rd_rdat",   64'(rd_m[0]), 64'h0141);
    check("rd_frame",  cap_m[0], 64'hFFFFFFFF_608A0141);
    check("rd_oe_low", 64'(oel_m[0]), 64'd18);
    check("rd_status", 64'(st_m[0]), 64'h80);
    $display("read: rdat=%h frame=%h", rd_m[0], cap_m[0]);
    ctrl[0] = '0;
    @(negedge clk);

    // Start held high for 1000 cycles.
    wdat[0] = 16'h1234;
    ctrl[0] = 7'b1100111;
    t0 = total_m[0];
    repeat (1000) @(negedge clk);
    check("held_rises",  64'(total_m[0] - t0), 64'd64);
    check("held_status", 64'(st_m[0]), 64'h80);
    check("held_frame",  cap_m[0], 64'hFFFFFFFF_509E1234);
    $display("held start: rises=%0d", total_m[0] - t0);
    ctrl[0] = '0;

    // Start edge in the middle of a poll.
    wait_oe_rise(1, 2000, ok);
    check("mid_poll_start", 64'(ok), 64'h1);
    repeat (20) @(negedge clk);
    wdat[1] = 16'hBEEF;
    ctrl[1] = 7'b1100011;
    @(negedge clk);
    check("mid_ready_low", 64'(st_m[1][7]), 64'h0);
    wait_rises(1, 64, 600, ok);
    check("mid_poll_end", 64'(ok), 64'h1);
    check("mid_idle_mdc", 64'(mdc_m[1]), 64'h0);
    check("mid_idle_oe",  64'(oe_m[1]), 64'h0);
    @(negedge clk);
    check("mid_user_begin", 64'(oe_m[1]), 64'h1);
    wait_status(1, 8'h80, 8'h80, 600, ok, dropped);
    check("mid_user_done", 64'(ok), 64'h1);
    check("mid_frame",     cap_m[1], 64'hFFFFFFFF_508EBEEF);
    check("mid_status",    64'(st_m[1]), 64'hD3);
    $display("write after poll: frame=%h status=%h", cap_m[1], st_m[1]);
    ctrl[1] = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
